// File: rtl/bcd_countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer_pkg
// Shared definitions for the BCD countdown timer and its up-counting sibling:
//   - controller state encoding
//   - count limit and switch width
//   - default prescaler divisors for a 100 MHz board clock
//   - active-low 7-segment patterns (gfedcba, DP in bit 7)
//   - small helpers for double-dabble, BCD decrement and segment lookup
// ---------------------------------------------------------------------------
package bcd_countdown_timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    RUN     = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int         START_W   = 10;
  localparam logic [9:0] MAX_COUNT = 10'd999;

  localparam int DEFAULT_TICK_DIV = 100_000_000;
  localparam int DEFAULT_SCAN_DIV = 262_144;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Nibbles above 9 cannot come from a valid count, so they blank the digit.
  function automatic logic [7:0] seg_of(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: a digit of 5 or more would overflow past 9
  // when doubled, so it is pre-biased by 3 before the shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Decrement a three-digit BCD value with borrow; 000 stays 000.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hund;
    ones = v[3:0];
    tens = v[7:4];
    hund = v[11:8];
    if (v == 12'h000) begin
      return v;
    end
    if (ones != 4'd0) begin
      ones = ones - 4'd1;
    end else begin
      ones = 4'd9;
      if (tens != 4'd0) begin
        tens = tens - 4'd1;
      end else begin
        tens = 4'd9;
        hund = hund - 4'd1;
      end
    end
    return {hund, tens, ones};
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer_if
// Control and display bundle of the countdown timer.
//   Start        single-cycle load/start request        (master -> slave)
//   Pause        level, holds the count while high      (master -> slave)
//   Start_Value  binary start value, clamped to 999     (master -> slave)
//   Busy         high while converting, running, paused (slave -> master)
//   Done         high once the count reached 000        (slave -> master)
//   Anode        active-low digit enables               (slave -> master)
//   Display      active-low segments gfedcba, DP bit 7  (slave -> master)
// ---------------------------------------------------------------------------
interface bcd_countdown_timer_if;
  import bcd_countdown_timer_pkg::*;

  logic               Start;
  logic               Pause;
  logic [START_W-1:0] Start_Value;
  logic               Busy;
  logic               Done;
  logic [7:0]         Anode;
  logic [7:0]         Display;

  modport master (
    output Start, Pause, Start_Value,
    input  Busy, Done, Anode, Display
  );

  modport slave (
    input  Start, Pause, Start_Value,
    output Busy, Done, Anode, Display
  );

endinterface

// File: rtl/bcd_countdown_timer_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble: converts a 10-bit binary value (<= 999) into
// three BCD digits, one input bit per cycle.
//   Clk    system clock
//   Reset  synchronous, active-high
//   Load   captures Bin and starts a new conversion (restarts one in flight)
//   Bin    binary input
//   Bcd    converted value, meaningful while Valid is high
//   Valid  one-cycle pulse during the 10th shift cycle after Load
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bcd_countdown_timer_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Load,
  input  logic [START_W-1:0] Bin,
  output logic [11:0]        Bcd,
  output logic               Valid
);

  logic [START_W-1:0] bin_q, bin_d;
  logic [11:0]        bcd_q, bcd_d;
  logic [3:0]         iter_q, iter_d;
  logic               active_q, active_d;

  logic [11:0]        adj;
  logic [11:0]        step_bcd;
  logic [START_W-1:0] step_bin;

  // One shift-add-3 iteration. The 10th iteration's result is presented
  // combinationally so the caller can capture it on the closing edge of the
  // 10th cycle; the hundreds digit never reaches 5 before the final shift
  // because inputs are at most 999, so the dropped MSB is always zero.
  always_comb begin
    adj      = {dd_adjust(bcd_q[11:8]), dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};
    step_bcd = {adj[10:0], bin_q[START_W-1]};
    step_bin = {bin_q[START_W-2:0], 1'b0};
  end

  assign Bcd   = step_bcd;
  assign Valid = active_q && (iter_q == 4'd9);

  // Iteration control: Load wins over an ongoing conversion.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    active_d = active_q;
    if (Load) begin
      bin_d    = Bin;
      bcd_d    = 12'h000;
      iter_d   = 4'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      bin_d  = step_bin;
      bcd_d  = step_bcd;
      iter_d = iter_q + 4'd1;
      if (iter_q == 4'd9) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
// Three-digit BCD countdown timer with a multiplexed active-low 7-segment
// display. A start value is converted to BCD, then decremented once per
// tick until 000, where Done is raised.
//   Clk    system clock, rising edge
//   Reset  synchronous, active-high
//   bus    slave side of bcd_countdown_timer_if (Start, Pause, Start_Value,
//          Busy, Done, Anode, Display)
// Parameters:
//   TICK_DIV  clock cycles per count tick
//   SCAN_DIV  clock cycles per digit-scan step
// ---------------------------------------------------------------------------
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
  input logic                  Clk,
  input logic                  Reset,
  bcd_countdown_timer_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  state_e              state_q, state_d;
  logic [11:0]         count_q, count_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [1:0]          idx_q, idx_d;
  logic [7:0]          anode_q, anode_d;
  logic [7:0]          display_q, display_d;

  logic                busy;
  logic                done;
  logic                conv_load;
  logic                conv_valid;
  logic [11:0]         conv_bcd;
  logic [START_W-1:0]  start_clamped;
  logic                tick_run;
  logic                tick_wrap;
  logic [11:0]         count_dec;
  logic [3:0]          digit;

  assign start_clamped = (bus.Start_Value > MAX_COUNT) ? MAX_COUNT : bus.Start_Value;
  assign tick_wrap     = (tick_q == TICK_LAST);
  assign count_dec     = bcd_dec(count_q);

  bin2bcd_seq u_bin2bcd (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (conv_load),
    .Bin   (start_clamped),
    .Bcd   (conv_bcd),
    .Valid (conv_valid)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A restart request beats both Pause and a tick that
  // lands in the same cycle; the last decrement to 000 goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) state_d = CONVERT;
      end
      CONVERT: begin
        if (conv_valid) state_d = (conv_bcd == 12'h000) ? DONE : RUN;
      end
      RUN: begin
        if (bus.Start) begin
          state_d = CONVERT;
        end else if (bus.Pause) begin
          state_d = PAUSED;
        end else if (tick_wrap && (count_dec == 12'h000)) begin
          state_d = DONE;
        end
      end
      PAUSED: begin
        if (bus.Start) begin
          state_d = CONVERT;
        end else if (!bus.Pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.Start) state_d = CONVERT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state outputs. The tick prescaler only advances in RUN when neither
  // Start nor Pause is requested, so pausing freezes it mid-period.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    conv_load = 1'b0;
    tick_run  = 1'b0;
    case (state_q)
      IDLE: begin
        conv_load = bus.Start;
      end
      CONVERT: begin
        busy = 1'b1;
      end
      RUN: begin
        busy      = 1'b1;
        conv_load = bus.Start;
        tick_run  = !bus.Start && !bus.Pause;
      end
      PAUSED: begin
        busy      = 1'b1;
        conv_load = bus.Start;
      end
      DONE: begin
        done      = 1'b1;
        conv_load = bus.Start;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Count and tick prescaler. A finished conversion loads the count and
  // restarts the prescaler so the first decrement is a full period away.
  always_comb begin
    count_d = count_q;
    tick_d  = tick_q;
    if (conv_valid) begin
      count_d = conv_bcd;
      tick_d  = '0;
    end else if (tick_run) begin
      if (tick_wrap) begin
        tick_d  = '0;
        count_d = count_dec;
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= 12'h000;
      tick_q  <= '0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  // Free-running display scan: the index walks 0, 1, 2 and the anode and
  // segment registers follow it one cycle later.
  always_comb begin
    scan_d    = scan_q + SCAN_W'(1);
    idx_d     = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);
    end
    case (idx_q)
      2'd0:    begin digit = count_q[3:0];  anode_d = 8'hFE; end
      2'd1:    begin digit = count_q[7:4];  anode_d = 8'hFD; end
      default: begin digit = count_q[11:8]; anode_d = 8'hFB; end
    endcase
    display_d = seg_of(digit);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan_q    <= '0;
      idx_q     <= 2'd0;
      anode_q   <= 8'hFE;
      display_q <= SEG_0;
    end else begin
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      display_q <= display_d;
    end
  end

  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.Anode   = anode_q;
  assign bus.Display = display_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_countdown_timer
// Directed and randomized stimulus for bcd_countdown_timer, checked every
// cycle against a decimal-integer model of the timer and display scan.
// ---------------------------------------------------------------------------
module tb_bcd_countdown_timer;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic clk = 1'b0;
  logic reset;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  // Reference model: count as a plain decimal integer plus activity flags.
  int         m_cnt;
  bit         m_conv;
  int         m_conv_left;
  int         m_conv_val;
  bit         m_run;
  bit         m_paused;
  bit         m_done;
  int         m_elapsed;
  int         m_edges;
  logic [7:0] exp_anode;
  logic [7:0] exp_display;
  logic [7:0] seg_tbl [10];
  bit         rnd_pause;

  function automatic int digitOf(input int value, input int idx);
    if (idx == 0) return value % 10;
    if (idx == 1) return (value / 10) % 10;
    return value / 100;
  endfunction

  // Advance the model by one clock edge with the inputs present at that edge.
  task automatic modelEdge(input bit s, input bit p, input int v, input bit r);
    int idx;
    if (r) begin
      m_cnt = 0; m_conv = 0; m_conv_left = 0; m_conv_val = 0;
      m_run = 0; m_paused = 0; m_done = 0; m_elapsed = 0; m_edges = 0;
      exp_anode = 8'hFE; exp_display = 8'hC0;
      return;
    end
    idx         = (m_edges / SCAN_DIV) % 3;
    exp_anode   = 8'hFF & ~(8'h01 << idx);
    exp_display = seg_tbl[digitOf(m_cnt, idx)];
    m_edges++;
    if (m_conv) begin
      m_conv_left--;
      if (m_conv_left == 0) begin
        m_conv = 0;
        m_cnt  = m_conv_val;
        if (m_cnt == 0) m_done = 1;
        else begin m_run = 1; m_elapsed = 0; end
      end
    end else if (s) begin
      m_conv = 1; m_conv_left = 10; m_conv_val = (v > 999) ? 999 : v;
      m_run = 0; m_paused = 0; m_done = 0;
    end else if (m_run) begin
      if (p) begin
        m_run = 0; m_paused = 1;
      end else begin
        m_elapsed++;
        if (m_elapsed == TICK_DIV) begin
          m_elapsed = 0;
          m_cnt--;
          if (m_cnt == 0) begin m_run = 0; m_done = 1; end
        end
      end
    end else if (m_paused) begin
      if (!p) begin m_paused = 0; m_run = 1; end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic exp_busy;
    logic exp_done;
    exp_busy = m_conv | m_run | m_paused;
    exp_done = m_done;
    check_count++;
    assert (bus.Busy === exp_busy) begin pass_count++; end
    else begin fail_count++; $error("[TB] FAIL %s busy: got %b expected %b", tag, bus.Busy, exp_busy); end
    check_count++;
    assert (bus.Done === exp_done) begin pass_count++; end
    else begin fail_count++; $error("[TB] FAIL %s done: got %b expected %b", tag, bus.Done, exp_done); end
    check_count++;
    assert (bus.Anode === exp_anode) begin pass_count++; end
    else begin fail_count++; $error("[TB] FAIL %s anode: got %h expected %h", tag, bus.Anode, exp_anode); end
    check_count++;
    assert (bus.Display === exp_display) begin pass_count++; end
    else begin fail_count++; $error("[TB] FAIL %s display: got %h expected %h", tag, bus.Display, exp_display); end
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic applyStimulus(input bit s, input bit p, input int v, input bit r, input string tag);
    reset           = r;
    bus.Start       = s;
    bus.Pause       = p;
    bus.Start_Value = 10'(v);
    @(posedge clk);
    modelEdge(s, p, v, r);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input bit p, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, p, 0, 1'b0, tag);
  endtask

  // Step until the requested digit is being driven, then check its segments.
  task automatic waitDigit(input logic [7:0] anode, input logic [7:0] seg, input bit p, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (bus.Anode === anode) break;
      applyStimulus(1'b0, p, 0, 1'b0, tag);
    end
    check_count++;
    assert (bus.Anode === anode) begin pass_count++; end
    else begin fail_count++; $error("[TB] FAIL %s digit-wait: got anode %h expected %h", tag, bus.Anode, anode); end
    check_count++;
    assert (bus.Display === seg) begin pass_count++; end
    else begin fail_count++; $error("[TB] FAIL %s digit: got %h expected %h", tag, bus.Display, seg); end
  endtask

  initial begin
    seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    rnd_pause = 1'b0;
    reset = 1'b1;
    bus.Start = 1'b0;
    bus.Pause = 1'b0;
    bus.Start_Value = '0;
    @(negedge clk);

    // Reset, then idle with the scan walking across the three digits.
    applyStimulus(1'b0, 1'b0, 0, 1'b1, "reset");
    applyStimulus(1'b0, 1'b0, 0, 1'b1, "reset");
    idleCycles(20, 1'b0, "idle");

    // Count down from 3 to Done and hold there.
    applyStimulus(1'b1, 1'b0, 3, 1'b0, "start3");
    idleCycles(10, 1'b0, "convert3");
    idleCycles(16, 1'b0, "count3");

    // 100 -> 099 borrow across both digits; pause to read the digits.
    applyStimulus(1'b1, 1'b0, 100, 1'b0, "start100");
    idleCycles(14, 1'b0, "run100");
    waitDigit(8'hFB, 8'hC0, 1'b1, "hund099");
    waitDigit(8'hFE, 8'h90, 1'b1, "ones099");
    waitDigit(8'hFD, 8'h90, 1'b1, "tens099");

    // Out-of-range value clamps to 999 (restart from PAUSED).
    applyStimulus(1'b1, 1'b1, 1023, 1'b0, "start1023");
    idleCycles(12, 1'b0, "run999");
    waitDigit(8'hFB, 8'h90, 1'b1, "hund999");
    waitDigit(8'hFE, 8'h90, 1'b1, "ones999");

    // Zero goes straight to Done after conversion.
    applyStimulus(1'b1, 1'b0, 0, 1'b0, "start0");
    idleCycles(12, 1'b0, "zero");

    // Pause part-way through a tick period at 050.
    applyStimulus(1'b1, 1'b0, 50, 1'b0, "start50");
    idleCycles(12, 1'b0, "run50");
    idleCycles(12, 1'b1, "pause50");
    waitDigit(8'hFD, 8'h92, 1'b1, "tens050");
    idleCycles(6, 1'b1, "pause50");
    idleCycles(10, 1'b0, "resume50");

    // Restart coinciding with a tick, then reset in the middle of CONVERT.
    applyStimulus(1'b1, 1'b0, 20, 1'b0, "start20");
    idleCycles(13, 1'b0, "run20");
    applyStimulus(1'b1, 1'b0, 7, 1'b0, "restart7");
    idleCycles(5, 1'b0, "convert7");
    applyStimulus(1'b1, 1'b0, 9, 1'b1, "midreset");
    idleCycles(6, 1'b0, "postreset");

    // Randomized traffic, biased toward small values so Done is reached.
    for (int i = 0; i < 600; i++) begin
      bit s;
      bit r;
      int v;
      s = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 7) == 0) rnd_pause = !rnd_pause;
      v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023));
      applyStimulus(s, rnd_pause, v, r, "random");
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
